// File: rtl/hd44780_responder.sv
// HD44780-compatible LCD device model: samples the 8-bit controller bus, executes the
// instruction subset the controller uses, keeps an 80-byte DDRAM and models busy timing.
module hd44780_responder #(
    parameter int INIT_CYCLES  = 2000000,
    parameter int CLR_CYCLES   = 100000,
    parameter int INSTR_CYCLES = 1950,
    parameter int DATA_CYCLES  = 2150,
    parameter int PWEH_MIN     = 7
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       e,
    input  logic       rs,
    input  logic       rw,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       busy,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       lines2,
    output logic       font_5x10,
    output logic       entry_inc,
    output logic       entry_shift,
    output logic       wr_strobe,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_char,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_char,
    output logic [4:0] viol
);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_EXEC, ST_CLEAR} state_t;

    state_t      state_reg, state_next;
    logic [31:0] cnt_reg, cnt_next;
    logic [6:0]  fill_reg, fill_next;

    logic [2:0]  e_sync_reg, rs_sync_reg, rw_sync_reg;
    logic [7:0]  d_s1_reg, d_s2_reg, d_s3_reg;
    logic [7:0]  width_reg;

    logic        txn_valid_reg, txn_rs_reg, txn_rw_reg;
    logic [7:0]  txn_data_reg;
    logic [6:0]  ac_reg;

    logic [7:0]  mem [0:79];
    logic        mem_we;
    logic [6:0]  mem_widx;
    logic [7:0]  mem_wdata;

    logic        busy_int, fall, short_pulse, bf_read, exec;
    logic [6:0]  ac_idx, rd_idx;

    // Line 1 (0x00-0x27) maps to 0..39, line 2 (0x40-0x67) to 40..79.
    function automatic logic [6:0] ddram_index(input logic [6:0] a);
        return a[6] ? ({1'b0, a[5:0]} + 7'd40) : a;
    endfunction

    function automatic logic ddram_ok(input logic [6:0] a);
        return a[5:0] <= 6'd39;
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        logic [6:0] r;
        if (inc) begin
            if (a == 7'h27)      r = 7'h40;
            else if (a == 7'h67) r = 7'h00;
            else                 r = a + 7'd1;
        end else begin
            if (a == 7'h00)      r = 7'h67;
            else if (a == 7'h40) r = 7'h27;
            else                 r = a - 7'd1;
        end
        return r;
    endfunction

    assign fall        = e_sync_reg[2] & ~e_sync_reg[1];
    assign short_pulse = width_reg < 8'(PWEH_MIN - 1);
    assign bf_read     = ~rs_sync_reg[2] & rw_sync_reg[2];
    assign exec        = txn_valid_reg && (state_reg == ST_IDLE);
    assign ac_idx      = ddram_index(ac_reg);
    assign rd_idx      = ddram_index(rd_addr);
    assign busy        = busy_int;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            e_sync_reg  <= '0;
            rs_sync_reg <= '0;
            rw_sync_reg <= '0;
            d_s1_reg    <= '0;
            d_s2_reg    <= '0;
            d_s3_reg    <= '0;
            width_reg   <= '0;
        end else begin
            e_sync_reg  <= {e_sync_reg[1:0], e};
            rs_sync_reg <= {rs_sync_reg[1:0], rs};
            rw_sync_reg <= {rw_sync_reg[1:0], rw};
            d_s1_reg    <= data_in;
            d_s2_reg    <= d_s1_reg;
            d_s3_reg    <= d_s2_reg;
            // Counts cycles of stage-3 E high; width_reg + 1 is the pulse width at the fall.
            if (!e_sync_reg[2])
                width_reg <= '0;
            else if (width_reg != 8'hFF)
                width_reg <= width_reg + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            txn_valid_reg <= 1'b0;
            txn_rs_reg    <= 1'b0;
            txn_rw_reg    <= 1'b0;
            txn_data_reg  <= '0;
        end else begin
            txn_valid_reg <= fall & ~short_pulse & ~bf_read & ~busy_int;
            if (fall) begin
                txn_rs_reg   <= rs_sync_reg[2];
                txn_rw_reg   <= rw_sync_reg[2];
                txn_data_reg <= d_s3_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_reg <= ST_INIT;
            cnt_reg   <= 32'(INIT_CYCLES - 1);
            fill_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            fill_reg  <= fill_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        fill_next  = fill_reg;
        case (state_reg)
            ST_INIT, ST_CLEAR, ST_EXEC: begin
                if (fill_reg != 7'd80)
                    fill_next = fill_reg + 7'd1;
                if (cnt_reg == '0)
                    state_next = ST_IDLE;
                else
                    cnt_next = cnt_reg - 32'd1;
            end
            default: begin
                if (txn_valid_reg) begin
                    if (!txn_rs_reg && txn_data_reg == 8'h01) begin
                        state_next = ST_CLEAR;
                        fill_next  = '0;
                        cnt_next   = 32'(CLR_CYCLES - 1);
                    end else begin
                        state_next = ST_EXEC;
                        if (txn_rs_reg)
                            cnt_next = 32'(DATA_CYCLES - 1);
                        else if (txn_data_reg[7:1] == 7'b0000001)
                            cnt_next = 32'(CLR_CYCLES - 1);
                        else
                            cnt_next = 32'(INSTR_CYCLES - 1);
                    end
                end
            end
        endcase
    end

    always_comb begin
        busy_int  = (state_reg != ST_IDLE);
        mem_we    = 1'b0;
        mem_widx  = fill_reg;
        mem_wdata = 8'h20;
        if ((state_reg == ST_INIT || state_reg == ST_CLEAR) && fill_reg < 7'd80) begin
            mem_we = 1'b1;
        end else if (exec && txn_rs_reg && !txn_rw_reg) begin
            mem_we    = 1'b1;
            mem_widx  = ac_idx;
            mem_wdata = txn_data_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_widx] <= mem_wdata;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)
            rd_char <= '0;
        else
            rd_char <= (rd_idx < 7'd80) ? mem[rd_idx] : 8'h00;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            data_oe  <= 1'b0;
            data_out <= '0;
        end else begin
            data_oe  <= e_sync_reg[1] & rw_sync_reg[1];
            if (e_sync_reg[1] && rw_sync_reg[1])
                data_out <= rs_sync_reg[1] ? mem[ac_idx] : {busy_int, ac_reg};
            else
                data_out <= '0;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ac_reg      <= '0;
            disp_on     <= 1'b0;
            cursor_on   <= 1'b0;
            blink_on    <= 1'b0;
            lines2      <= 1'b0;
            font_5x10   <= 1'b0;
            entry_inc   <= 1'b1;
            entry_shift <= 1'b0;
            wr_strobe   <= 1'b0;
            wr_addr     <= '0;
            wr_char     <= '0;
            viol        <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (fall) begin
                if (short_pulse)
                    viol[1] <= 1'b1;
                else if (!bf_read && busy_int)
                    viol[0] <= 1'b1;
            end
            if (exec) begin
                if (txn_rs_reg) begin
                    if (!txn_rw_reg) begin
                        wr_strobe <= 1'b1;
                        wr_addr   <= ac_reg;
                        wr_char   <= txn_data_reg;
                    end
                    ac_reg <= ac_step(ac_reg, entry_inc);
                end else begin
                    casez (txn_data_reg)
                        8'b1???????: begin
                            if (ddram_ok(txn_data_reg[6:0])) ac_reg <= txn_data_reg[6:0];
                            else                             viol[4] <= 1'b1;
                        end
                        8'b01??????: viol[3] <= 1'b1;
                        8'b001?????: begin
                            lines2    <= txn_data_reg[3];
                            font_5x10 <= txn_data_reg[2];
                            if (!txn_data_reg[4]) viol[2] <= 1'b1;
                        end
                        8'b0001????: begin
                            if (!txn_data_reg[3]) ac_reg <= ac_step(ac_reg, txn_data_reg[2]);
                        end
                        8'b00001???: begin
                            disp_on   <= txn_data_reg[2];
                            cursor_on <= txn_data_reg[1];
                            blink_on  <= txn_data_reg[0];
                        end
                        8'b000001??: begin
                            entry_inc   <= txn_data_reg[1];
                            entry_shift <= txn_data_reg[0];
                        end
                        8'b0000001?: ac_reg <= '0;
                        8'b00000001: begin
                            ac_reg    <= '0;
                            entry_inc <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_hd44780_responder.sv
// Directed bench for hd44780_responder with shortened busy periods; one line per bus transaction.
module tb_hd44780_responder;

    localparam int INIT  = 300;
    localparam int CLR   = 120;
    localparam int INSTR = 30;
    localparam int DATA  = 35;
    localparam int PW    = 7;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       e = 1'b0, rs = 1'b0, rw = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [6:0] rd_addr = 7'h00;
    logic [7:0] data_out, wr_char, rd_char;
    logic       data_oe, busy, disp_on, cursor_on, blink_on, lines2, font_5x10;
    logic       entry_inc, entry_shift, wr_strobe;
    logic [6:0] wr_addr;
    logic [4:0] viol;

    hd44780_responder #(
        .INIT_CYCLES(INIT), .CLR_CYCLES(CLR), .INSTR_CYCLES(INSTR),
        .DATA_CYCLES(DATA), .PWEH_MIN(PW)
    ) dut (
        .clk(clk), .n_reset(n_reset), .e(e), .rs(rs), .rw(rw), .data_in(data_in),
        .data_out(data_out), .data_oe(data_oe), .busy(busy), .disp_on(disp_on),
        .cursor_on(cursor_on), .blink_on(blink_on), .lines2(lines2), .font_5x10(font_5x10),
        .entry_inc(entry_inc), .entry_shift(entry_shift), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .wr_char(wr_char), .rd_addr(rd_addr), .rd_char(rd_char),
        .viol(viol)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [6:0] log_addr [$];
    logic [7:0] log_char [$];

    always @(negedge clk) begin
        if (n_reset && wr_strobe) begin
            log_addr.push_back(wr_addr);
            log_char.push_back(wr_char);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic rs_v, input logic rw_v, input logic [7:0] d, input int width);
        @(negedge clk);
        rs = rs_v; rw = rw_v; data_in = d; e = 1'b1;
        repeat (width) @(negedge clk);
        e = 1'b0;
        $display("txn rs=%0d rw=%0d data=0x%02h e_width=%0d", rs_v, rw_v, d, width);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk({tag, "_timeout"}, 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic cmd(input logic rs_v, input logic [7:0] d);
        send(rs_v, 1'b0, d, PW);
        repeat (4) @(negedge clk);
        wait_idle("cmd");
    endtask

    task automatic read_bus(input logic rs_v, output logic [7:0] v, output logic oe);
        @(negedge clk);
        rs = rs_v; rw = 1'b1; e = 1'b1;
        repeat (6) @(negedge clk);
        v  = data_out;
        oe = data_oe;
        @(negedge clk);
        e = 1'b0;
        $display("txn rs=%0d rw=1 read=0x%02h", rs_v, v);
        repeat (4) @(negedge clk);
        rw = 1'b0;
    endtask

    task automatic peek(input logic [6:0] a, output logic [7:0] v);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        v = rd_char;
    endtask

    initial begin
        logic [7:0] v;
        logic       oe;
        logic [6:0] a;
        logic [7:0] exp_chars [4];
        int         n;
        exp_chars = '{8'h31, 8'h38, 8'h30, 8'hDF};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_entry_inc", 32'(entry_inc), 32'd1);
        chk("rst_viol", 32'(viol), 32'd0);
        chk("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        chk("rst_data_oe", 32'(data_oe), 32'd0);
        chk("rst_disp_on", 32'(disp_on), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);

        // Power-on busy period and DDRAM fill
        n_reset = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < INIT + 50) begin
            @(negedge clk);
            n++;
        end
        chk("init_busy_len", 32'(n), 32'(INIT));
        for (int i = 0; i < 80; i++) begin
            a = (i < 40) ? 7'(i) : 7'(i - 40 + 64);
            peek(a, v);
            chk($sformatf("init_fill_%02h", a), 32'(v), 32'h20);
        end
        chk("init_viol", 32'(viol), 32'd0);

        // Controller init sequence, with exact clear busy timing
        cmd(1'b0, 8'h38);
        cmd(1'b0, 8'h38);
        cmd(1'b0, 8'h0C);
        send(1'b0, 1'b0, 8'h01, PW);
        repeat (3) @(negedge clk);
        chk("clr_busy_k2", 32'(busy), 32'd0);
        @(negedge clk);
        chk("clr_busy_k3", 32'(busy), 32'd1);
        n = 0;
        while (busy === 1'b1 && n < CLR + 50) begin
            @(negedge clk);
            n++;
        end
        chk("clr_busy_len", 32'(n), 32'(CLR));
        repeat (2) @(negedge clk);
        cmd(1'b0, 8'h06);
        chk("ctl_lines2", 32'(lines2), 32'd1);
        chk("ctl_disp_on", 32'(disp_on), 32'd1);
        chk("ctl_entry_inc", 32'(entry_inc), 32'd1);
        chk("ctl_cursor_on", 32'(cursor_on), 32'd0);
        chk("ctl_blink_on", 32'(blink_on), 32'd0);
        chk("ctl_viol", 32'(viol), 32'd0);

        // Data writes "180" + degree sign, first one timed
        log_addr.delete();
        log_char.delete();
        send(1'b1, 1'b0, 8'h31, PW);
        repeat (3) @(negedge clk);
        chk("wr_strobe_k2", 32'(wr_strobe), 32'd0);
        @(negedge clk);
        chk("wr_strobe_k3", 32'(wr_strobe), 32'd1);
        chk("wr_addr_k3", 32'(wr_addr), 32'h00);
        chk("wr_char_k3", 32'(wr_char), 32'h31);
        n = 0;
        while (busy === 1'b1 && n < DATA + 50) begin
            @(negedge clk);
            n++;
        end
        chk("data_busy_len", 32'(n), 32'(DATA));
        repeat (2) @(negedge clk);
        cmd(1'b1, 8'h38);
        cmd(1'b1, 8'h30);
        cmd(1'b1, 8'hDF);
        chk("wr_count", 32'(log_addr.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            chk($sformatf("wr_addr_%0d", i), 32'(log_addr[i]), 32'(i));
            chk($sformatf("wr_char_%0d", i), 32'(log_char[i]), 32'(exp_chars[i]));
        end
        peek(7'h02, v);
        chk("rd_char_02", 32'(v), 32'h30);
        read_bus(1'b0, v, oe);
        chk("bf_oe", 32'(oe), 32'd1);
        chk("bf_ac_04", 32'(v), 32'h04);

        // Line wraps on increment and decrement
        cmd(1'b0, 8'hA7);
        cmd(1'b1, 8'h41);
        cmd(1'b1, 8'h42);
        chk("wrap_count", 32'(log_addr.size()), 32'd6);
        if (log_addr.size() >= 6) begin
            chk("wrap_addr_27", 32'(log_addr[4]), 32'h27);
            chk("wrap_addr_40", 32'(log_addr[5]), 32'h40);
        end
        peek(7'h27, v);
        chk("rd_char_27", 32'(v), 32'h41);
        peek(7'h40, v);
        chk("rd_char_40", 32'(v), 32'h42);
        cmd(1'b0, 8'h80);
        cmd(1'b0, 8'h04);
        chk("entry_dec", 32'(entry_inc), 32'd0);
        cmd(1'b1, 8'h43);
        read_bus(1'b0, v, oe);
        chk("bf_ac_67", 32'(v), 32'h67);
        cmd(1'b0, 8'h06);

        // Clear issued while busy after a data write is dropped
        send(1'b1, 1'b0, 8'h58, PW);
        repeat (3) @(negedge clk);
        send(1'b0, 1'b0, 8'h01, PW);
        repeat (4) @(negedge clk);
        wait_idle("busy_viol");
        chk("viol0", 32'(viol), 32'h01);
        peek(7'h67, v);
        chk("busy_rd_67", 32'(v), 32'h58);
        peek(7'h00, v);
        chk("busy_rd_00", 32'(v), 32'h43);
        read_bus(1'b0, v, oe);
        chk("busy_ac", 32'(v), 32'h00);

        // Short E pulse, bad DDRAM address, DL=0, CGRAM address
        send(1'b0, 1'b0, 8'h0F, 3);
        repeat (10) @(negedge clk);
        chk("viol1", 32'(viol), 32'h03);
        chk("short_cursor", 32'(cursor_on), 32'd0);
        cmd(1'b0, 8'hA8);
        chk("viol4", 32'(viol), 32'h13);
        read_bus(1'b0, v, oe);
        chk("viol4_ac", 32'(v), 32'h00);
        cmd(1'b0, 8'h20);
        chk("viol2", 32'(viol), 32'h17);
        chk("fs_lines2", 32'(lines2), 32'd0);
        cmd(1'b0, 8'h40);
        chk("viol3", 32'(viol), 32'h1F);

        // Data read and cursor shift
        cmd(1'b0, 8'h80);
        read_bus(1'b1, v, oe);
        chk("rd_oe", 32'(oe), 32'd1);
        chk("rd_data", 32'(v), 32'h43);
        repeat (2) @(negedge clk);
        wait_idle("rd");
        read_bus(1'b0, v, oe);
        chk("rd_ac_adv", 32'(v), 32'h01);
        cmd(1'b0, 8'h10);
        read_bus(1'b0, v, oe);
        chk("shift_left", 32'(v), 32'h00);
        cmd(1'b0, 8'h10);
        read_bus(1'b0, v, oe);
        chk("shift_wrap", 32'(v), 32'h67);

        // Busy-flag read mid-clear, then reset during CLEAR
        send(1'b0, 1'b0, 8'h01, PW);
        repeat (10) @(negedge clk);
        read_bus(1'b0, v, oe);
        chk("bf_midclear", 32'(v), 32'h80);
        @(negedge clk);
        n_reset = 1'b0;
        @(negedge clk);
        chk("rst2_busy", 32'(busy), 32'd1);
        chk("rst2_viol", 32'(viol), 32'd0);
        chk("rst2_disp_on", 32'(disp_on), 32'd0);
        @(negedge clk);
        n_reset = 1'b1;
        read_bus(1'b0, v, oe);
        chk("rst2_bf", 32'(v), 32'h80);
        wait_idle("rst2");
        peek(7'h67, v);
        chk("rst2_fill_67", 32'(v), 32'h20);
        peek(7'h00, v);
        chk("rst2_fill_00", 32'(v), 32'h20);
        chk("rst2_viol_end", 32'(viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
